ps2_key_encoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_frame_rx.sv | 141 ++++++++++++++
 rtl/ps2_key_encoder.sv | 66 ++++++
 tb/tb_ps2_key_encoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
// Build option PS2_KEY_PARITY_CHECK_EN enables odd-parity checking in ps2_frame_rx.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;

    // Bytes that follow E1 in the Pause make-sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    function automatic logic is_response(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deframer with mid-frame timeout.
// With PS2_KEY_PARITY_CHECK_EN defined, bytes failing odd parity are dropped.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    r_clk_sync, r_dat_sync;
    logic [FW-1:0] r_flt_cnt;
    logic          r_clk_flt;
    logic          w_accept, w_fall, w_din, w_timeout;
    frame_state_e  r_state, w_state_nx;
    logic [2:0]    r_bit_cnt, w_bit_cnt_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic [TW-1:0] r_to_cnt;
`ifdef PS2_KEY_PARITY_CHECK_EN
    logic          r_par_ok, w_par_ok_nx;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
        end
    end

    // A level change is accepted only after FILTER_LEN consecutive differing samples
    assign w_accept = (r_clk_sync[1] != r_clk_flt) && (r_flt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall   = w_accept && r_clk_flt;
    assign w_din    = r_dat_sync[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flt_cnt <= '0;
            r_clk_flt <= 1'b1;
        end else if (r_clk_sync[1] == r_clk_flt) begin
            r_flt_cnt <= '0;
        end else if (w_accept) begin
            r_clk_flt <= r_clk_sync[1];
            r_flt_cnt <= '0;
        end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
        end
    end

    // An edge in the expiring cycle keeps the frame alive
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_to_cnt <= '0;
        else if (r_state == ST_IDLE || w_fall || w_timeout)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef PS2_KEY_PARITY_CHECK_EN
            r_par_ok  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_shift   <= w_shift_nx;
`ifdef PS2_KEY_PARITY_CHECK_EN
            r_par_ok  <= w_par_ok_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt;
        w_shift_nx   = r_shift;
        o_byte_valid = 1'b0;
        o_frame_err  = 1'b0;
`ifdef PS2_KEY_PARITY_CHECK_EN
        w_par_ok_nx  = r_par_ok;
`endif
        if (w_timeout) begin
            w_state_nx  = ST_IDLE;
            o_frame_err = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_din) begin
                        w_state_nx   = ST_DATA;
                        w_bit_cnt_nx = '0;
                    end
                end
                ST_DATA: begin
                    w_shift_nx   = {w_din, r_shift[7:1]};
                    w_bit_cnt_nx = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7)
                        w_state_nx = ST_PARITY;
                end
                ST_PARITY: begin
`ifdef PS2_KEY_PARITY_CHECK_EN
                    w_par_ok_nx = (^r_shift) ^ w_din;
`endif
                    w_state_nx = ST_STOP;
                end
                ST_STOP: begin
                    w_state_nx = ST_IDLE;
`ifdef PS2_KEY_PARITY_CHECK_EN
                    if (w_din && r_par_ok) o_byte_valid = 1'b1;
                    else                   o_frame_err  = 1'b1;
`else
                    if (w_din) o_byte_valid = 1'b1;
                    else       o_frame_err  = 1'b1;
`endif
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign o_byte = r_shift;

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to ps2_key event word: deframing plus E0/F0/E1 prefix resolution.
// Build option PS2_KEY_PARITY_CHECK_EN turns on parity checking in the deframer.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    logic [7:0]  w_byte;
    logic        w_byte_valid;
    logic [10:0] r_key;
    logic        r_ext, r_brk;
    logic [2:0]  r_skip;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk        (clk),
        .i_rst        (reset),
        .i_ps2_clk    (ps2_clk_in),
        .i_ps2_data   (ps2_data_in),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (frame_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key  <= '0;
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
        end else if (w_byte_valid) begin
            if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
            end else if (w_byte == PS2_EXT) begin
                r_ext <= 1'b1;
            end else if (w_byte == PS2_BRK) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                if (w_byte == PS2_PAUSE) begin
                    r_skip <= PAUSE_SKIP;
                end else if (!is_response(w_byte)) begin
                    r_key[KEY_TOGGLE]  <= ~r_key[KEY_TOGGLE];
                    r_key[KEY_PRESSED] <= ~r_brk;
                    r_key[KEY_EXT]     <= r_ext;
                    r_key[7:0]         <= w_byte;
                end
            end
        end
    end

    assign ps2_key = r_key;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed + randomized bench for ps2_key_encoder against a byte-level reference model.
module tb_ps2_key_encoder;

    localparam int TOUT = 1000;
    localparam int HALF = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;

    logic [10:0] m_key;
    bit          m_ext, m_brk;
    int          m_skip;
    int          m_err;

    ps2_key_encoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk),
        .ps2_data_in (ps2_data),
        .ps2_key     (ps2_key),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!reset && frame_err) err_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic model_reset();
        m_key = '0; m_ext = 0; m_brk = 0; m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (b == 8'hE1) m_skip = 7;
            else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}))
                m_key = {~m_key[10], ~m_brk, m_ext, b};
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic bad_par, input logic bad_stop);
        bit ok;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        cyc(HALF);
        @(negedge clk);
        ok = !bad_stop;
`ifdef PS2_KEY_PARITY_CHECK_EN
        if (bad_par) ok = 0;
`endif
        if (ok) model_byte(b);
        else    m_err++;
        chk({tag, "_key"}, 32'(ps2_key), 32'(m_key));
        chk({tag, "_err"}, 32'(err_cnt), 32'(m_err));
    endtask

    task automatic partial_frame();
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
    endtask

    initial begin
        logic [7:0] pool [9];
        logic [7:0] b;
        pool = '{8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        model_reset();
        m_err = 0;

        cyc(5);
        @(negedge clk);
        chk("rst_key", 32'(ps2_key), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        cyc(10);

        send_byte("make15", 8'h15, 0, 0);
        chk("make15_lit", 32'(ps2_key), 32'h615);
        send_byte("brkF0", 8'hF0, 0, 0);
        chk("brkF0_hold", 32'(ps2_key), 32'h615);
        send_byte("brk15", 8'h15, 0, 0);
        chk("brk15_lit", 32'(ps2_key), 32'h015);

        send_byte("e0", 8'hE0, 0, 0);
        send_byte("e0_4a", 8'h4A, 0, 0);
        chk("e0_4a_lit", 32'(ps2_key), 32'h74A);
        send_byte("e0b", 8'hE0, 0, 0);
        send_byte("e0f0", 8'hF0, 0, 0);
        send_byte("e0f0_4a", 8'h4A, 0, 0);
        chk("e0f0_4a_lit", 32'(ps2_key), 32'h14A);

        foreach (pool[i]) if (i == 2) send_byte("pause_e1", pool[i], 0, 0);
        send_byte("pause_14", 8'h14, 0, 0);
        send_byte("pause_77", 8'h77, 0, 0);
        send_byte("pause_e1b", 8'hE1, 0, 0);
        send_byte("pause_f0", 8'hF0, 0, 0);
        send_byte("pause_14b", 8'h14, 0, 0);
        send_byte("pause_f0b", 8'hF0, 0, 0);
        send_byte("pause_77b", 8'h77, 0, 0);
        chk("pause_hold", 32'(ps2_key), 32'h14A);
        send_byte("after_pause", 8'h1C, 0, 0);
        chk("after_pause_lit", 32'(ps2_key), 32'h61C);
        send_byte("ack_fa", 8'hFA, 0, 0);

        send_byte("bad_par", 8'h15, 1, 0);
        send_byte("bad_stop", 8'h2B, 0, 1);

        // Short low pulse on ps2_clk with data low must not start a frame
        ps2_data = 1'b0;
        cyc(3);
        ps2_clk = 1'b0;
        cyc(2);
        ps2_clk = 1'b1;
        cyc(10);
        ps2_data = 1'b1;
        cyc(10);
        send_byte("post_glitch", 8'h33, 0, 0);

        partial_frame();
        cyc(TOUT - 200);
        @(negedge clk);
        chk("tout_early", 32'(err_cnt), 32'(m_err));
        cyc(400);
        @(negedge clk);
        m_err++;
        chk("tout_fire", 32'(err_cnt), 32'(m_err));
        chk("tout_key", 32'(ps2_key), 32'(m_key));
        send_byte("post_tout", 8'h15, 0, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 3) b = pool[$urandom_range(0, 8)];
            else b = 8'($urandom_range(0, 255));
            send_byte($sformatf("rnd%0d", n), b, 0, 0);
        end

        partial_frame();
        cyc(3);
        reset = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("midrst_key", 32'(ps2_key), 32'h0);
        chk("midrst_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        model_reset();
        cyc(20);
        send_byte("post_rst", 8'h15, 0, 0);
        chk("post_rst_lit", 32'(ps2_key), 32'h615);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
